// File: rtl/alu_issue_decoder_pkg.sv
// +-------------------------------------------------------------------------+
// | Module : tinuc_pkg                                                      |
// | Shared TinuC decode types: ALU op codes, opcodes, decoded instruction.  |
// | Rev    : 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

package tinuc_pkg;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'b00000,
      ALU_SUB  = 5'b00001,
      ALU_SLL  = 5'b00010,
      ALU_SLT  = 5'b00011,
      ALU_SLTU = 5'b00100,
      ALU_XOR  = 5'b00101,
      ALU_SRL  = 5'b00110,
      ALU_SRA  = 5'b00111,
      ALU_OR   = 5'b01000,
      ALU_AND  = 5'b01001
   } alu_op_t;

   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_branch = 7'b1100011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;

   typedef struct packed {
      logic [31:0] src_a;
      logic [31:0] src_b;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] link_addr;
      logic [31:0] store_data;
      alu_op_t     alu_op;
      logic [4:0]  rd_addr;
      logic        rd_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        is_branch;
      logic        branch_ne;
      logic        is_jump;
      logic        illegal;
   } decoded_t;

   // alt selects SUB for funct3=000 and SRA for funct3=101
   function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_decoder_if.sv
// +-------------------------------------------------------------------------+
// | Module : alu_issue_decoder_if                                           |
// | Issue bus from the decode stage to the ALU/EX stage.                    |
// | Rev    : 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

interface alu_issue_decoder_if;
   import tinuc_pkg::*;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] src_a;
   logic [31:0] src_b;
   alu_op_t     alu_control;
   logic [31:0] imm_out;
   logic [31:0] pc_out;
   logic [31:0] link_addr;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] store_data;
   logic        is_branch;
   logic        branch_ne;
   logic        is_jump;
   logic        illegal;

   modport master (
      output out_valid, src_a, src_b, alu_control, imm_out, pc_out, link_addr,
             rd_addr, rd_we, mem_rd, mem_wr, store_data, is_branch, branch_ne,
             is_jump, illegal,
      input  out_ready
   );

   modport slave (
      input  out_valid, src_a, src_b, alu_control, imm_out, pc_out, link_addr,
             rd_addr, rd_we, mem_rd, mem_wr, store_data, is_branch, branch_ne,
             is_jump, illegal,
      output out_ready
   );

endinterface

`default_nettype wire

// File: rtl/alu_issue_decoder_imm_gen.sv
// +-------------------------------------------------------------------------+
// | Module : imm_gen                                                        |
// | Sign-extended I/S/B/U/J immediates from an instruction word.            |
// | Rev    : 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module imm_gen (
   input  logic [31:7] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

`default_nettype wire

// File: rtl/alu_issue_decoder.sv
// +-------------------------------------------------------------------------+
// | Module : alu_issue_decoder                                              |
// | TinuC decode/issue: builds ALU operands, registers them in ID/EX.       |
// | Rev    : 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module alu_issue_decoder
   import tinuc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [31:0]     pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   alu_issue_decoder_if.master iss
);

   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_writes_rd;
   logic        w_load;
   decoded_t    w_dec;
   decoded_t    r_dec;
   logic        r_valid;

   imm_gen u_imm_gen (
      .instr (instr[31:7]),
      .imm_i (w_imm_i),
      .imm_s (w_imm_s),
      .imm_b (w_imm_b),
      .imm_u (w_imm_u),
      .imm_j (w_imm_j)
   );

   assign w_opc    = instr[6:0];
   assign w_f3     = instr[14:12];
   assign w_f7     = instr[31:25];
   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];

   always_comb begin
      w_dec           = '0;
      w_dec.alu_op    = ALU_ADD;
      w_dec.pc        = pc;
      w_dec.link_addr = pc + 32'd4;
      w_dec.rd_addr   = instr[11:7];
      w_writes_rd     = 1'b0;
      case (w_opc)
         c_opc_op: begin
            w_dec.src_a   = rs1_data;
            w_dec.src_b   = rs2_data;
            w_dec.alu_op  = f3_to_op(w_f3, instr[30]);
            w_writes_rd   = 1'b1;
            w_dec.illegal = !((w_f7 == 7'b0000000) ||
                              (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
         end
         c_opc_op_imm: begin
            w_dec.src_a  = rs1_data;
            w_dec.src_b  = w_imm_i;
            w_dec.imm    = w_imm_i;
            // Only the shift encodings carry funct7; bit 30 on other funct3 is immediate
            w_dec.alu_op = f3_to_op(w_f3, (w_f3 == 3'b101) && instr[30]);
            w_writes_rd  = 1'b1;
            if (w_f3 == 3'b001)
               w_dec.illegal = (w_f7 != 7'b0000000);
            else if (w_f3 == 3'b101)
               w_dec.illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
         end
         c_opc_load: begin
            w_dec.src_a   = rs1_data;
            w_dec.src_b   = w_imm_i;
            w_dec.imm     = w_imm_i;
            w_dec.mem_rd  = 1'b1;
            w_writes_rd   = 1'b1;
            w_dec.illegal = (w_f3 != 3'b010);
         end
         c_opc_store: begin
            w_dec.src_a      = rs1_data;
            w_dec.src_b      = w_imm_s;
            w_dec.imm        = w_imm_s;
            w_dec.store_data = rs2_data;
            w_dec.mem_wr     = 1'b1;
            w_dec.illegal    = (w_f3 != 3'b010);
         end
         c_opc_branch: begin
            w_dec.src_a     = rs1_data;
            w_dec.src_b     = rs2_data;
            w_dec.imm       = w_imm_b;
            w_dec.alu_op    = ALU_SUB;
            w_dec.is_branch = 1'b1;
            w_dec.branch_ne = w_f3[0];
            w_dec.illegal   = (w_f3[2:1] != 2'b00);
         end
         c_opc_lui: begin
            w_dec.src_b = w_imm_u;
            w_dec.imm   = w_imm_u;
            w_writes_rd = 1'b1;
         end
         c_opc_auipc: begin
            w_dec.src_a = pc;
            w_dec.src_b = w_imm_u;
            w_dec.imm   = w_imm_u;
            w_writes_rd = 1'b1;
         end
         c_opc_jal: begin
            w_dec.src_a   = pc;
            w_dec.src_b   = w_imm_j;
            w_dec.imm     = w_imm_j;
            w_dec.is_jump = 1'b1;
            w_writes_rd   = 1'b1;
         end
         c_opc_jalr: begin
            w_dec.src_a   = rs1_data;
            w_dec.src_b   = w_imm_i;
            w_dec.imm     = w_imm_i;
            w_dec.is_jump = 1'b1;
            w_writes_rd   = 1'b1;
            w_dec.illegal = (w_f3 != 3'b000);
         end
         default: w_dec.illegal = 1'b1;
      endcase

      // An illegal instruction still issues, but with every side effect suppressed
      if (w_dec.illegal) begin
         w_dec.alu_op     = ALU_ADD;
         w_dec.src_a      = '0;
         w_dec.src_b      = '0;
         w_dec.imm        = '0;
         w_dec.store_data = '0;
         w_dec.mem_rd     = 1'b0;
         w_dec.mem_wr     = 1'b0;
         w_dec.is_branch  = 1'b0;
         w_dec.branch_ne  = 1'b0;
         w_dec.is_jump    = 1'b0;
         w_writes_rd      = 1'b0;
      end
      w_dec.rd_we = w_writes_rd && (instr[11:7] != 5'd0);
   end

   assign in_ready = !r_valid || iss.out_ready;
   assign w_load   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_dec   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_dec   <= w_dec;
      end else if (iss.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign iss.out_valid   = r_valid;
   assign iss.src_a       = r_dec.src_a;
   assign iss.src_b       = r_dec.src_b;
   assign iss.alu_control = r_dec.alu_op;
   assign iss.imm_out     = r_dec.imm;
   assign iss.pc_out      = r_dec.pc;
   assign iss.link_addr   = r_dec.link_addr;
   assign iss.rd_addr     = r_dec.rd_addr;
   assign iss.rd_we       = r_dec.rd_we;
   assign iss.mem_rd      = r_dec.mem_rd;
   assign iss.mem_wr      = r_dec.mem_wr;
   assign iss.store_data  = r_dec.store_data;
   assign iss.is_branch   = r_dec.is_branch;
   assign iss.branch_ne   = r_dec.branch_ne;
   assign iss.is_jump     = r_dec.is_jump;
   assign iss.illegal     = r_dec.illegal;

endmodule

`default_nettype wire

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
- Decode/issue stage that produces the ALU's inputs: `src_a`, `src_b` and the 5-bit ALU control code.
- Decodes one 32-bit TinuC (RV32 subset) instruction per cycle. Combines it with the PC and register-file read data.
- Registers the result into a single-entry ID/EX pipeline register with valid/ready handshake and flush.
- Sits between fetch/regfile and the ALU.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the held and the incoming instruction (branch taken/exception)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_addr  out  5  combinational = instr[19:15], to regfile
- rs2_addr  out  5  combinational = instr[24:20], to regfile
- rs1_data  in  32  regfile read data, same cycle
- rs2_data  in  32  regfile read data, same cycle
- out_valid  out  1  registered operands valid
- out_ready  in  1  EX consumes
- src_a  out  32  ALU operand A
- src_b  out  32  ALU operand B
- alu_control  out  5  ALU op code
- imm_out  out  32  sign-extended immediate (branch offset, store offset)
- pc_out  out  32  PC of the issued instruction
- link_addr  out  32  pc+4 for JAL/JALR
- rd_addr  out  5  destination register
- rd_we  out  1  writeback enable; 0 when rd==0
- mem_rd  out  1  LOAD
- mem_wr  out  1  STORE
- store_data  out  32  rs2_data for STORE
- is_branch  out  1  BEQ/BNE
- branch_ne  out  1  1=BNE, 0=BEQ
- is_jump  out  1  JAL/JALR
- illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n=0): out_valid=0. All registered outputs are 0, including alu_control=ADD (00000) and illegal=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in on in_valid && in_ready; the register loads at the next edge and out_valid=1.
  - Output is held stable while out_valid && !out_ready.
  - Latency: 1 cycle.
  - Pass-through: out_valid && out_ready && in_valid loads the new instruction the same edge; there is no bubble.
  - out_valid && out_ready && !in_valid clears out_valid.
- flush: at the next edge out_valid=0 and any concurrent input transfer is dropped. Flush has priority over load. in_ready is unaffected.
- Operand selection by opcode (instr[6:0]):
  - OP 0110011: src_a=rs1, src_b=rs2.
    - funct3 map: 000 ADD/SUB (instr[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (instr[30]), 110 OR, 111 AND.
    - funct7 other than 0000000/0100000, or 0100000 with funct3 not in {000,101}: illegal.
  - OP-IMM 0010011: src_a=rs1, src_b=imm_i. Same funct3 map; no SUB.
    - SLLI requires funct7=0.
    - SRLI/SRAI require funct7 in {0000000, 0100000}.
  - LOAD 0000011 (funct3=010 only): ADD, rs1+imm_i, mem_rd=1.
  - STORE 0100011 (funct3=010): ADD, rs1+imm_s, mem_wr=1, rd_we=0.
  - BRANCH 1100011: funct3 000/001 only, else illegal. SUB, rs1−rs2, is_branch=1, imm_out=imm_b, rd_we=0.
  - LUI 0110111: ADD, src_a=0, src_b=imm_u.
  - AUIPC 0010111: ADD, src_a=pc, src_b=imm_u.
  - JAL 1101111: ADD, src_a=pc, src_b=imm_j, is_jump=1.
  - JALR 1100111 (funct3=000): ADD, rs1+imm_i, is_jump=1.
- Illegal instructions: out_valid still asserts with illegal=1, alu_control=ADD, rd_we=mem_rd=mem_wr=is_branch=is_jump=0.
- Width rules:
  - Immediates are sign-extended from instr[31].
  - link_addr = pc+4, modulo 2^32; 0xFFFFFFFC gives 0.
- rs1_addr/rs2_addr are driven regardless of opcode.

Decomposition:
- Package tinuc_pkg holds:
  - alu_op_t enum: ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001. The ALU imports the same enum.
  - Opcode localparams.
  - A decoded-instruction struct.
- Sub-module imm_gen: combinational, instr → imm_i/s/b/u/j.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2), rs1_data=5, rs2_data=7 → next cycle out_valid=1, alu_control=00000, src_a=5, src_b=7, rd_addr=3, rd_we=1.
- 0x402081B3 → alu_control=00001. 0xFFF00093 (ADDI x1,x0,-1) → src_b=0xFFFFFFFF, src_a=rs1_data.
- 0x123452B7 (LUI x5) → src_a=0, src_b=0x12345000, alu_control=ADD.
- 0x00208463 (BEQ x1,x2,+8), pc=0x100 → alu_control=SUB, is_branch=1, branch_ne=0, imm_out=8, pc_out=0x100, rd_we=0.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable. Release → the two instructions issue back-to-back with no bubble.
- flush with in_valid=1 → out_valid=0 next cycle.
- 0x00000000 → illegal=1, rd_we=0.
- rst_n low mid-stall → out_valid=0 immediately.
